// File: rtl/neurons_layer_seq_if.sv
// Handshake and weight-load bundle for the time-multiplexed binary-input neuron layer.
// i_* are inputs to the layer and o_* are outputs from it; the slave modport is the layer side.
interface neurons_layer_seq_if #(
    parameter int unsigned N_IN  = 64,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned W_W   = 16
);
    localparam int unsigned ADDR_W = $clog2(N_IN * N_OUT);

    logic                   i_wen;
    logic [ADDR_W-1:0]      i_weight_addr;
    logic [W_W-1:0]         i_weight_in;
    logic                   i_start;
    logic [N_IN-1:0]        i_image;
    logic                   o_busy;
    logic                   o_done;
    logic [N_OUT*W_W-1:0]   o_neurons_output;

    modport slave (
        input  i_wen, i_weight_addr, i_weight_in, i_start, i_image,
        output o_busy, o_done, o_neurons_output
    );

    modport master (
        output i_wen, i_weight_addr, i_weight_in, i_start, i_image,
        input  o_busy, o_done, o_neurons_output
    );
endinterface

// File: rtl/neurons_layer_seq.sv
// Binary-input neuron layer: N_OUT neurons share one pass over a latched image, LANES bits per
// cycle, then each accumulator is shifted, saturated and optionally clamped at zero.
module neurons_layer_seq #(
    parameter int unsigned N_IN  = 64,
    parameter int unsigned N_OUT = 4,
    parameter int unsigned W_W   = 16,
    parameter int unsigned LANES = 8,
    parameter int unsigned SHIFT = 0,
    parameter int unsigned RELU  = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    neurons_layer_seq_if.slave    bus
);
    localparam int unsigned S      = N_IN / LANES;
    localparam int unsigned ACC_W  = W_W + $clog2(N_IN);
    localparam int unsigned ADDR_W = $clog2(N_IN * N_OUT);
    localparam int unsigned STEP_W = (S > 1) ? $clog2(S) : 1;
    localparam int unsigned IMG_AW = (N_IN > 1) ? $clog2(N_IN) : 1;

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-W_W+1){1'b0}}, {(W_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-W_W+1){1'b1}}, {(W_W-1){1'b0}}};
    localparam logic [W_W-1:0]          OUT_MAX = {1'b0, {(W_W-1){1'b1}}};
    localparam logic [W_W-1:0]          OUT_MIN = {1'b1, {(W_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StFinish} state_t;

    state_t                  r_state;
    logic [STEP_W-1:0]       r_step;
    logic [N_IN-1:0]         r_img;
    logic signed [W_W-1:0]   r_weights [N_OUT*N_IN];
    logic signed [ACC_W-1:0] r_acc [N_OUT];
    logic [N_OUT*W_W-1:0]    r_out;
    logic                    r_busy;
    logic                    r_done;

    logic signed [ACC_W-1:0] w_step_sum [N_OUT];
    logic signed [ACC_W-1:0] w_shifted [N_OUT];
    logic [W_W-1:0]          w_result [N_OUT];
    logic [IMG_AW-1:0]       w_img_idx;
    logic [ADDR_W-1:0]       w_w_idx;

    // Partial sum of the current LANES-wide slice for every neuron.
    always_comb begin
        w_img_idx = '0;
        w_w_idx   = '0;
        for (int n = 0; n < int'(N_OUT); n++) begin
            w_step_sum[n] = '0;
            for (int k = 0; k < int'(LANES); k++) begin
                w_img_idx = IMG_AW'(int'(r_step) * int'(LANES) + k);
                w_w_idx   = ADDR_W'(n * int'(N_IN) + int'(r_step) * int'(LANES) + k);
                if (r_img[w_img_idx]) begin
                    w_step_sum[n] = w_step_sum[n] + $signed(
                        {{(ACC_W-W_W){r_weights[w_w_idx][W_W-1]}}, r_weights[w_w_idx]});
                end
            end
        end
    end

    always_comb begin
        for (int n = 0; n < int'(N_OUT); n++) begin
            w_shifted[n] = r_acc[n] >>> SHIFT;
            if (w_shifted[n] > SAT_MAX) begin
                w_result[n] = OUT_MAX;
            end else if (w_shifted[n] < SAT_MIN) begin
                w_result[n] = OUT_MIN;
            end else begin
                w_result[n] = w_shifted[n][W_W-1:0];
            end
            if ((RELU != 0) && (w_shifted[n] < 0)) begin
                w_result[n] = '0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
            r_step  <= '0;
            r_img   <= '0;
            r_out   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int n = 0; n < int'(N_OUT); n++) begin
                r_acc[n] <= '0;
            end
            for (int a = 0; a < int'(N_OUT * N_IN); a++) begin
                r_weights[a] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // A write in the same cycle as start lands before the first RUN step reads it.
                    if (bus.i_wen) begin
                        r_weights[bus.i_weight_addr] <= bus.i_weight_in;
                    end
                    if (bus.i_start) begin
                        r_img   <= bus.i_image;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                        for (int n = 0; n < int'(N_OUT); n++) begin
                            r_acc[n] <= '0;
                        end
                    end
                end
                StRun: begin
                    for (int n = 0; n < int'(N_OUT); n++) begin
                        r_acc[n] <= r_acc[n] + w_step_sum[n];
                    end
                    r_step <= r_step + STEP_W'(1);
                    if (r_step == STEP_W'(S - 1)) begin
                        r_state <= StFinish;
                    end
                end
                StFinish: begin
                    for (int n = 0; n < int'(N_OUT); n++) begin
                        r_out[n*W_W +: W_W] <= w_result[n];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_busy           = r_busy;
    assign bus.o_done           = r_done;
    assign bus.o_neurons_output = r_out;
endmodule

// File: tb/tb_neurons_layer_seq.sv
// Drives a RELU=1 and a RELU=0 layer with identical stimulus and checks both against constant
// vectors, hand-written handshake sequences and a plain-arithmetic reference model.
module tb_neurons_layer_seq;
    localparam int unsigned N_IN  = 64;
    localparam int unsigned N_OUT = 4;
    localparam int unsigned W_W   = 16;
    localparam int unsigned LANES = 8;
    localparam int unsigned SHIFT = 0;
    localparam int unsigned S     = N_IN / LANES;
    localparam int unsigned AW    = $clog2(N_IN * N_OUT);
    localparam int unsigned OW    = N_OUT * W_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neurons_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W)) bus_r ();
    neurons_layer_seq_if #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W)) bus_l ();

    neurons_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .LANES(LANES), .SHIFT(SHIFT), .RELU(1)
    ) dut_relu (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus_r)
    );

    neurons_layer_seq #(
        .N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .LANES(LANES), .SHIFT(SHIFT), .RELU(0)
    ) dut_lin (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus_l)
    );

    int n_checks = 0;
    int n_errors = 0;
    int model_w [N_OUT*N_IN];

    typedef struct {
        int              n;
        logic [W_W-1:0]  w;
        logic [N_IN-1:0] img;
        logic [OW-1:0]   exp_r;
        logic [OW-1:0]   exp_l;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: sum selected weights, arithmetic shift, clamp to W_W bits, optional ReLU.
    function automatic logic [OW-1:0] model_out(input logic [N_IN-1:0] img, input bit relu);
        logic [OW-1:0] r = '0;
        for (int n = 0; n < int'(N_OUT); n++) begin
            longint acc = 0;
            for (int i = 0; i < int'(N_IN); i++) begin
                if (img[i]) acc += longint'(model_w[n*N_IN + i]);
            end
            acc = acc >>> SHIFT;
            if (acc > 32767) acc = 32767;
            if (acc < -32768) acc = -32768;
            if (relu && acc < 0) acc = 0;
            r[n*W_W +: W_W] = acc[W_W-1:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wen, input logic [AW-1:0] addr, input logic [W_W-1:0] d,
                         input logic start, input logic [N_IN-1:0] img);
        bus_r.i_wen = wen;   bus_r.i_weight_addr = addr; bus_r.i_weight_in = d;
        bus_r.i_start = start; bus_r.i_image = img;
        bus_l.i_wen = wen;   bus_l.i_weight_addr = addr; bus_l.i_weight_in = d;
        bus_l.i_start = start; bus_l.i_image = img;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, '0);
        repeat (cycles) tick();
        rst = 1'b0;
        for (int a = 0; a < int'(N_OUT * N_IN); a++) model_w[a] = 0;
    endtask

    task automatic write_w(input logic [AW-1:0] addr, input logic [W_W-1:0] d);
        drive(1'b1, addr, d, 1'b0, '0);
        tick();
        drive(1'b0, '0, '0, 1'b0, '0);
        model_w[addr] = int'($signed(d));
    endtask

    // Start a run (optionally with a same-cycle write), scramble the image pin, wait for done.
    task automatic run(input string name, input logic [N_IN-1:0] img, input logic wen,
                       input logic [AW-1:0] addr, input logic [W_W-1:0] d,
                       input logic [OW-1:0] exp_r, input logic [OW-1:0] exp_l);
        int cnt = 0;
        bit got = 0;
        drive(wen, addr, d, 1'b1, img);
        if (wen) model_w[addr] = int'($signed(d));
        tick();
        drive(1'b0, '0, '0, 1'b0, ~img);
        check({name, " busy"}, OW'({bus_r.o_busy, bus_l.o_busy}), OW'(2'b11));
        while (!got && cnt < int'(3 * S)) begin
            tick();
            cnt++;
            if (bus_r.o_done || bus_l.o_done) got = 1;
        end
        check({name, " done both"}, OW'({bus_r.o_done, bus_l.o_done}), OW'(2'b11));
        check({name, " latency"}, OW'(cnt), OW'(S + 1));
        check({name, " out relu"}, bus_r.o_neurons_output, exp_r);
        check({name, " out lin"}, bus_l.o_neurons_output, exp_l);
        tick();
        check({name, " idle after"},
              OW'({bus_r.o_done, bus_l.o_done, bus_r.o_busy, bus_l.o_busy}), '0);
    endtask

    task automatic load_neuron(input int n, input logic [W_W-1:0] w);
        for (int i = 0; i < int'(N_IN); i++) write_w(AW'(n * int'(N_IN) + i), w);
    endtask

    initial begin
        logic [N_IN-1:0] ones;
        logic [N_IN-1:0] img;
        logic [OW-1:0]   er;
        logic [OW-1:0]   el;
        int dones;
        ones = '1;

        vecs[0] = '{0, 16'h0001, {N_IN{1'b1}}, 64'h0000_0000_0000_0040, 64'h0000_0000_0000_0040};
        vecs[1] = '{1, 16'hFF00, 64'h0000_0000_0000_00FF, 64'h0, 64'h0000_0000_F800_0000};
        vecs[2] = '{2, 16'h7FFF, {N_IN{1'b1}}, 64'h0000_7FFF_0000_0000, 64'h0000_7FFF_0000_0000};
        vecs[3] = '{3, 16'h8000, {N_IN{1'b1}}, 64'h0, 64'h8000_0000_0000_0000};
        vecs[4] = '{0, 16'hFFFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 64'h0000_0000_0000_FFE0};
        vecs[5] = '{2, 16'h0003, 64'h0F0F_0000_0000_0001, 64'h0000_001B_0000_0000,
                    64'h0000_001B_0000_0000};

        // Reset state, then a run with all-zero weights.
        do_reset(2);
        check("reset busy/done", OW'({bus_r.o_busy, bus_l.o_busy, bus_r.o_done, bus_l.o_done}), '0);
        check("reset out relu", bus_r.o_neurons_output, '0);
        check("reset out lin", bus_l.o_neurons_output, '0);
        img = {$urandom, $urandom};
        run("zero weights", img, 1'b0, '0, '0, '0, '0);

        for (int v = 0; v < 6; v++) begin
            do_reset(2);
            load_neuron(vecs[v].n, vecs[v].w);
            run($sformatf("vec%0d", v), vecs[v].img, 1'b0, '0, '0, vecs[v].exp_r, vecs[v].exp_l);
        end

        // Write and second start during RUN are dropped; exactly one done.
        do_reset(2);
        load_neuron(0, 16'h0001);
        drive(1'b0, '0, '0, 1'b1, ones);
        tick();
        drive(1'b0, '0, '0, 1'b0, ones);
        tick();
        drive(1'b1, '0, 16'h1234, 1'b1, ones);
        tick();
        drive(1'b0, '0, '0, 1'b0, ones);
        dones = 0;
        for (int c = 0; c < int'(3 * S); c++) begin
            tick();
            if (bus_r.o_done) dones++;
        end
        check("busy-run single done", OW'(dones), OW'(1));
        check("busy-run out", bus_r.o_neurons_output, 64'h0000_0000_0000_0040);
        run("dropped write", ones, 1'b0, '0, '0, 64'h40, 64'h40);
        write_w('0, 16'h1234);
        run("write after done", ones, 1'b0, '0, '0, 64'h1273, 64'h1273);
        run("write with start", ones, 1'b1, AW'(1), 16'h0005, 64'h1277, 64'h1277);

        // Reset at RUN step 3 discards everything; no done follows.
        do_reset(2);
        load_neuron(0, 16'h0001);
        run("pre-abort", ones, 1'b0, '0, '0, 64'h40, 64'h40);
        drive(1'b0, '0, '0, 1'b1, ones);
        tick();
        drive(1'b0, '0, '0, 1'b0, ones);
        repeat (3) tick();
        do_reset(1);
        check("abort busy/done", OW'({bus_r.o_busy, bus_l.o_busy, bus_r.o_done, bus_l.o_done}), '0);
        check("abort out", bus_r.o_neurons_output | bus_l.o_neurons_output, '0);
        dones = 0;
        for (int c = 0; c < int'(3 * S); c++) begin
            tick();
            if (bus_r.o_done || bus_l.o_done) dones++;
        end
        check("abort no done", OW'(dones), '0);
        run("abort weights cleared", ones, 1'b0, '0, '0, '0, '0);
        load_neuron(0, 16'h0001);
        run("after abort", ones, 1'b0, '0, '0, 64'h40, 64'h40);

        // Random weights and images against the reference model.
        for (int round = 0; round < 2; round++) begin
            do_reset(1);
            for (int a = 0; a < int'(N_IN * N_OUT); a++) begin
                if (round == 0) write_w(AW'(a), W_W'($urandom));
                else write_w(AW'(a), W_W'($urandom_range(0, 511)) - 16'd256);
            end
            for (int t = 0; t < 4; t++) begin
                img = {$urandom, $urandom};
                er = model_out(img, 1'b1);
                el = model_out(img, 1'b0);
                run($sformatf("rand%0d_%0d", round, t), img, 1'b0, '0, '0, er, el);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
